// File: rtl/calc_multi_port_if.sv
// Request/response bundle for calc_multi_port: per-channel command and operand
// inputs, per-channel response code and result outputs, all packed by channel.
interface calc_multi_port_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 32
);
  logic [NCH*4-1:0]  req_cmd_in;
  logic [NCH*DW-1:0] req_data_in;
  logic [NCH*2-1:0]  out_resp;
  logic [NCH*DW-1:0] out_data;

  modport master (
    output req_cmd_in,
    output req_data_in,
    input  out_resp,
    input  out_data
  );

  modport slave (
    input  req_cmd_in,
    input  req_data_in,
    output out_resp,
    output out_data
  );
endinterface

// File: rtl/calc_multi_port.sv
// N-channel two-beat request calculator. Each channel runs a small FSM
// (IDLE -> OP2 -> WAIT -> RESP). One shared add/sub unit and one shared shift
// unit are handed out by independent round-robin arbiters; invalid commands
// bypass arbitration and answer with an error response.
module calc_multi_port #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 32
) (
  input  logic             clk,
  input  logic             reset,
  calc_multi_port_if.slave bus
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW = $clog2(DW);

  localparam logic [3:0] CmdAdd = 4'd1;
  localparam logic [3:0] CmdSub = 4'd2;
  localparam logic [3:0] CmdShl = 4'd5;
  localparam logic [3:0] CmdShr = 4'd6;

  localparam logic [1:0] RespOk  = 2'd1;
  localparam logic [1:0] RespErr = 2'd2;

  typedef enum logic [1:0] {StIdle, StOp2, StWait, StResp} state_e;

  state_e          state_q    [NCH];
  state_e          state_d    [NCH];
  logic [3:0]      cmd_q      [NCH];
  logic [DW-1:0]   op1_q      [NCH];
  logic [DW-1:0]   op2_q      [NCH];
  logic [1:0]      res_resp_q [NCH];
  logic [DW-1:0]   res_data_q [NCH];

  logic [3:0]      cmd_in     [NCH];
  logic [DW-1:0]   data_in    [NCH];

  logic [NCH-1:0]  add_req, shf_req, inv_req;
  logic [NCH-1:0]  add_gnt, shf_gnt, gnt;
  logic [PW:0]     add_pick, shf_pick;
  logic [PW-1:0]   add_ptr_q, add_ptr_d, shf_ptr_q, shf_ptr_d;

  logic [DW-1:0]   add_a, add_b, add_res, shf_res;
  logic [DW:0]     add_sum;
  logic            add_ok;
  logic [SW-1:0]   shf_amt;

  // Round-robin pick: returns {valid, index} of the first request at or after ptr.
  function automatic logic [PW:0] rr_arb(input logic [NCH-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] pick;
    int unsigned idx;
    pick = '0;
    idx  = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!pick[PW] && req[PW'(idx)]) pick = {1'b1, PW'(idx)};
    end
    return pick;
  endfunction

  // Unpack the flat per-channel input buses.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      cmd_in[c]  = bus.req_cmd_in[4*c +: 4];
      data_in[c] = bus.req_data_in[DW*c +: DW];
    end
  end

  // Classify waiting channels by the unit their command needs.
  always_comb begin
    add_req = '0;
    shf_req = '0;
    inv_req = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (state_q[c] == StWait) begin
        if (cmd_q[c] == CmdAdd || cmd_q[c] == CmdSub)      add_req[c] = 1'b1;
        else if (cmd_q[c] == CmdShl || cmd_q[c] == CmdShr) shf_req[c] = 1'b1;
        else                                               inv_req[c] = 1'b1;
      end
    end
  end

  // Arbitrate both units and advance each pointer past its granted channel.
  always_comb begin
    add_pick  = rr_arb(add_req, add_ptr_q);
    shf_pick  = rr_arb(shf_req, shf_ptr_q);
    add_gnt   = add_pick[PW] ? (NCH'(1) << add_pick[PW-1:0]) : '0;
    shf_gnt   = shf_pick[PW] ? (NCH'(1) << shf_pick[PW-1:0]) : '0;
    gnt       = add_gnt | shf_gnt | inv_req;
    add_ptr_d = add_ptr_q;
    shf_ptr_d = shf_ptr_q;
    if (add_pick[PW]) begin
      add_ptr_d = (add_pick[PW-1:0] == PW'(NCH - 1)) ? '0 : add_pick[PW-1:0] + PW'(1);
    end
    if (shf_pick[PW]) begin
      shf_ptr_d = (shf_pick[PW-1:0] == PW'(NCH - 1)) ? '0 : shf_pick[PW-1:0] + PW'(1);
    end
  end

  // Shared add/sub and shift datapaths, operands muxed from the granted channel.
  always_comb begin
    add_a   = op1_q[add_pick[PW-1:0]];
    add_b   = op2_q[add_pick[PW-1:0]];
    add_sum = {1'b0, add_a} + {1'b0, add_b};
    if (cmd_q[add_pick[PW-1:0]] == CmdSub) begin
      add_ok  = (add_b <= add_a);
      add_res = add_a - add_b;
    end else begin
      add_ok  = !add_sum[DW];
      add_res = add_sum[DW-1:0];
    end
    shf_amt = op2_q[shf_pick[PW-1:0]][SW-1:0];
    if (cmd_q[shf_pick[PW-1:0]] == CmdShl) shf_res = op1_q[shf_pick[PW-1:0]] << shf_amt;
    else                                   shf_res = op1_q[shf_pick[PW-1:0]] >> shf_amt;
  end

  // Channel FSM state register.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (reset) state_q[c] <= StIdle;
      else       state_q[c] <= state_d[c];
    end
  end

  // Channel FSM next state; a nonzero cmd in RESP starts the next request at once.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      unique case (state_q[c])
        StIdle:  if (cmd_in[c] != 4'd0) state_d[c] = StOp2;
        StOp2:   state_d[c] = StWait;
        StWait:  if (gnt[c]) state_d[c] = StResp;
        StResp:  state_d[c] = (cmd_in[c] != 4'd0) ? StOp2 : StIdle;
        default: state_d[c] = StIdle;
      endcase
    end
  end

  // Outputs are only live during RESP.
  always_comb begin
    bus.out_resp = '0;
    bus.out_data = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (state_q[c] == StResp) begin
        bus.out_resp[2*c +: 2]   = res_resp_q[c];
        bus.out_data[DW*c +: DW] = res_data_q[c];
      end
    end
  end

  // Operand capture, result registration and arbiter pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        cmd_q[c]      <= '0;
        op1_q[c]      <= '0;
        op2_q[c]      <= '0;
        res_resp_q[c] <= '0;
        res_data_q[c] <= '0;
      end
      add_ptr_q <= '0;
      shf_ptr_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if ((state_q[c] == StIdle || state_q[c] == StResp) && cmd_in[c] != 4'd0) begin
          cmd_q[c] <= cmd_in[c];
          op1_q[c] <= data_in[c];
        end
        if (state_q[c] == StOp2) op2_q[c] <= data_in[c];
        if (add_gnt[c]) begin
          res_resp_q[c] <= add_ok ? RespOk : RespErr;
          res_data_q[c] <= add_ok ? add_res : '0;
        end else if (shf_gnt[c]) begin
          res_resp_q[c] <= RespOk;
          res_data_q[c] <= shf_res;
        end else if (inv_req[c]) begin
          res_resp_q[c] <= RespErr;
          res_data_q[c] <= '0;
        end
      end
      add_ptr_q <= add_ptr_d;
      shf_ptr_q <= shf_ptr_d;
    end
  end

endmodule

// File: tb/tb_calc_multi_port.sv
// Bench for calc_multi_port: directed scenarios plus a randomized run checked
// against a transaction-level model of channels and round-robin units.
module tb_calc_multi_port;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 32;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  calc_multi_port_if #(.NCH(NCH), .DW(DW)) bus ();

  calc_multi_port #(.NCH(NCH), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic [3:0] cmd, input logic [31:0] data);
    bus.req_cmd_in[4*c +: 4]   = cmd;
    bus.req_data_in[32*c +: 32] = data;
  endtask

  task automatic clear_inputs;
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [1:0] resp_of(input int c);
    return bus.out_resp[2*c +: 2];
  endfunction

  function automatic logic [31:0] data_of(input int c);
    return bus.out_data[32*c +: 32];
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    for (int c = 0; c < NCH; c++) drive(c, 4'd1, $urandom);
    tick();
    tick();
    tests++;
    if (bus.out_resp !== '0) begin
      fails++;
      $display("FAIL reset_resp: got %h want 0", bus.out_resp);
    end
    tests++;
    if (bus.out_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", bus.out_data);
    end
    reset = 1'b0;
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (bus.out_resp !== '0 || bus.out_data !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: resp=%h data=%h want 0", k, bus.out_resp, bus.out_data);
      end
    end
  endtask

  task automatic test_basic_add;
    do_reset();
    drive(0, 4'd1, 32'h1);
    tick();
    drive(0, 4'd0, 32'h2);
    tick();
    drive(0, 4'd0, 32'h0);
    tests++;
    if (resp_of(0) !== 2'd0) begin
      fails++;
      $display("FAIL basic_add cyc2: resp=%0d want 0", resp_of(0));
    end
    tick();
    tests++;
    if (resp_of(0) !== 2'd1 || data_of(0) !== 32'h3) begin
      fails++;
      $display("FAIL basic_add cyc3: resp=%0d data=%h want 1/3", resp_of(0), data_of(0));
    end
    tick();
    tests++;
    if (resp_of(0) !== 2'd0 || data_of(0) !== 32'h0) begin
      fails++;
      $display("FAIL basic_add cyc4: resp=%0d data=%h want 0/0", resp_of(0), data_of(0));
    end
  endtask

  task automatic test_overflow;
    logic [3:0]  t_cmd  [3] = '{4'd1, 4'd2, 4'd2};
    logic [31:0] t_a    [3] = '{32'hFFFF_FFFF, 32'd5, 32'd7};
    logic [31:0] t_b    [3] = '{32'd1, 32'd7, 32'd5};
    logic [1:0]  t_resp [3] = '{2'd2, 2'd2, 2'd1};
    logic [31:0] t_data [3] = '{32'd0, 32'd0, 32'd2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2, t_cmd[i], t_a[i]);
      tick();
      drive(2, 4'd0, t_b[i]);
      tick();
      drive(2, 4'd0, 32'd0);
      tick();
      tests++;
      if (resp_of(2) !== t_resp[i] || data_of(2) !== t_data[i]) begin
        fails++;
        $display("FAIL overflow case%0d: resp=%0d data=%h want %0d/%h",
                 i, resp_of(2), data_of(2), t_resp[i], t_data[i]);
      end
      tick();
    end
  endtask

  task automatic test_concurrent;
    do_reset();
    drive(0, 4'd1, 32'd3);
    drive(1, 4'd5, 32'h1);
    drive(3, 4'd3, 32'd0);
    tick();
    drive(0, 4'd0, 32'd4);
    drive(1, 4'd0, 32'd33);
    drive(3, 4'd0, 32'd9);
    tick();
    clear_inputs();
    tick();
    tests++;
    if (resp_of(0) !== 2'd1 || data_of(0) !== 32'd7) begin
      fails++;
      $display("FAIL concurrent_add: resp=%0d data=%h want 1/7", resp_of(0), data_of(0));
    end
    tests++;
    if (resp_of(1) !== 2'd1 || data_of(1) !== 32'h2) begin
      fails++;
      $display("FAIL concurrent_shl: resp=%0d data=%h want 1/2", resp_of(1), data_of(1));
    end
    tests++;
    if (resp_of(3) !== 2'd2 || data_of(3) !== 32'd0) begin
      fails++;
      $display("FAIL concurrent_inv: resp=%0d data=%h want 2/0", resp_of(3), data_of(3));
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] want;
    do_reset();
    drive(1, 4'd1, 32'd10);
    tick();
    drive(1, 4'd0, 32'd20);
    tick();
    clear_inputs();
    tick();
    tests++;
    if (resp_of(1) !== 2'd1 || data_of(1) !== 32'd30) begin
      fails++;
      $display("FAIL rr_ch1: resp=%0d data=%h want 1/30", resp_of(1), data_of(1));
    end
    tick();
    drive(0, 4'd1, 32'd1);
    drive(3, 4'd1, 32'd2);
    tick();
    drive(0, 4'd0, 32'd100);
    drive(3, 4'd0, 32'd200);
    tick();
    clear_inputs();
    tick();
    tests++;
    if (resp_of(3) !== 2'd1 || data_of(3) !== 32'd202 || resp_of(0) !== 2'd0) begin
      fails++;
      $display("FAIL rr_t3: ch3=%0d/%h ch0=%0d want ch3 1/ca ch0 0",
               resp_of(3), data_of(3), resp_of(0));
    end
    tick();
    tests++;
    if (resp_of(0) !== 2'd1 || data_of(0) !== 32'd101 || resp_of(3) !== 2'd0) begin
      fails++;
      $display("FAIL rr_t4: ch0=%0d/%h ch3=%0d want ch0 1/65 ch3 0",
               resp_of(0), data_of(0), resp_of(3));
    end
    do_reset();
    for (int c = 0; c < NCH; c++) drive(c, 4'd1, 32'(c + 1));
    tick();
    for (int c = 0; c < NCH; c++) drive(c, 4'd0, 32'(16 * (c + 1)));
    tick();
    clear_inputs();
    for (int k = 0; k < NCH; k++) begin
      tick();
      want = 8'(1 << (2 * k));
      tests++;
      if (bus.out_resp !== want || data_of(k) !== 32'(17 * (k + 1))) begin
        fails++;
        $display("FAIL rr_all cyc%0d: resp=%h data=%h want %h/%h",
                 k + 3, bus.out_resp, data_of(k), want, 32'(17 * (k + 1)));
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    drive(0, 4'd1, 32'd5);
    tick();
    drive(0, 4'd1, 32'd6);
    tick();
    drive(0, 4'd1, 32'd99);
    tick();
    tests++;
    if (resp_of(0) !== 2'd1 || data_of(0) !== 32'd11) begin
      fails++;
      $display("FAIL b2b_first: resp=%0d data=%h want 1/b", resp_of(0), data_of(0));
    end
    drive(0, 4'd1, 32'd20);
    tick();
    drive(0, 4'd0, 32'd22);
    for (int k = 4; k < 6; k++) begin
      tests++;
      if (resp_of(0) !== 2'd0) begin
        fails++;
        $display("FAIL b2b_gap cyc%0d: resp=%0d want 0", k, resp_of(0));
      end
      tick();
      clear_inputs();
    end
    tests++;
    if (resp_of(0) !== 2'd1 || data_of(0) !== 32'd42) begin
      fails++;
      $display("FAIL b2b_second: resp=%0d data=%h want 1/2a", resp_of(0), data_of(0));
    end
    tick();
    tests++;
    if (resp_of(0) !== 2'd0) begin
      fails++;
      $display("FAIL b2b_after: resp=%0d want 0", resp_of(0));
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(0, 4'd1, 32'd1);
    tick();
    drive(0, 4'd0, 32'd2);
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 3; k < 8; k++) begin
      tests++;
      if (bus.out_resp !== '0 || bus.out_data !== '0) begin
        fails++;
        $display("FAIL reset_mid cyc%0d: resp=%h data=%h want 0", k, bus.out_resp, bus.out_data);
      end
      tick();
    end
  endtask

  // Result of one operation from the arithmetic rules: {resp, data}.
  function automatic logic [33:0] ref_calc(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sum;
    case (cmd)
      4'd1: begin
        sum = longint'(a) + longint'(b);
        if (sum > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, 32'(sum)};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      4'd5:    return {2'd1, a << (b % 32)};
      4'd6:    return {2'd1, a >> (b % 32)};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic test_random;
    // Each channel holds at most one transaction, tracked by the cycle it was
    // accepted in and the cycle its response is due.
    bit          m_busy [NCH];
    bit          m_done [NCH];
    int          m_acc  [NCH];
    int          m_rcyc [NCH];
    logic [3:0]  m_cmd  [NCH];
    logic [31:0] m_op1  [NCH];
    logic [31:0] m_op2  [NCH];
    logic [33:0] m_res  [NCH];
    int          ptr    [2];
    logic [3:0]  cmd    [NCH];
    logic [31:0] dat    [NCH];
    logic [1:0]  er;
    logic [31:0] ed;
    bit          rst, found, is_unit, free;
    int          c;
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
    end
    ptr[0] = 0;
    ptr[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        er = 2'd0;
        ed = 32'd0;
        if (m_busy[i] && m_done[i] && m_rcyc[i] == n) begin
          er = m_res[i][33:32];
          ed = m_res[i][31:0];
        end
        tests++;
        if (resp_of(i) !== er || data_of(i) !== ed) begin
          fails++;
          $display("FAIL random ch%0d cyc%0d: resp=%0d data=%h want %0d/%h",
                   i, n, resp_of(i), data_of(i), er, ed);
        end
      end
      rst = ($urandom_range(0, 249) == 0);
      reset = rst;
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: cmd[i] = 4'd0;
          4, 5:       cmd[i] = 4'd1;
          6:          cmd[i] = 4'd2;
          7:          cmd[i] = 4'd5;
          8:          cmd[i] = 4'd6;
          default:    cmd[i] = 4'($urandom_range(0, 15));
        endcase
        case ($urandom_range(0, 3))
          0:       dat[i] = 32'($urandom_range(0, 8));
          1:       dat[i] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
          default: dat[i] = $urandom;
        endcase
        drive(i, cmd[i], dat[i]);
      end
      if (rst) begin
        for (int i = 0; i < NCH; i++) begin
          m_busy[i] = 0;
          m_done[i] = 0;
        end
        ptr[0] = 0;
        ptr[1] = 0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (m_busy[i] && !m_done[i] && m_acc[i] == n - 1) m_op2[i] = dat[i];
        end
        // Unit 0 serves ADD/SUB, unit 1 serves SHL/SHR.
        for (int u = 0; u < 2; u++) begin
          found = 0;
          for (int i = 0; i < NCH; i++) begin
            c = (ptr[u] + i) % NCH;
            is_unit = (u == 0) ? (m_cmd[c] == 4'd1 || m_cmd[c] == 4'd2)
                               : (m_cmd[c] == 4'd5 || m_cmd[c] == 4'd6);
            if (!found && m_busy[c] && !m_done[c] && m_acc[c] <= n - 2 && is_unit) begin
              found     = 1;
              m_done[c] = 1;
              m_rcyc[c] = n + 1;
              m_res[c]  = ref_calc(m_cmd[c], m_op1[c], m_op2[c]);
              ptr[u]    = (c + 1) % NCH;
            end
          end
        end
        for (int i = 0; i < NCH; i++) begin
          if (m_busy[i] && !m_done[i] && m_acc[i] <= n - 2 &&
              !(m_cmd[i] inside {4'd1, 4'd2, 4'd5, 4'd6})) begin
            m_done[i] = 1;
            m_rcyc[i] = n + 1;
            m_res[i]  = {2'd2, 32'd0};
          end
        end
        for (int i = 0; i < NCH; i++) begin
          free = !m_busy[i] || (m_done[i] && m_rcyc[i] == n);
          if (free && cmd[i] != 4'd0) begin
            m_busy[i] = 1;
            m_done[i] = 0;
            m_acc[i]  = n;
            m_cmd[i]  = cmd[i];
            m_op1[i]  = dat[i];
          end else if (free) begin
            m_busy[i] = 0;
            m_done[i] = 0;
          end
        end
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_add();
    test_overflow();
    test_concurrent();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_multi_port.md
Name: calc_multi_port

Overview:
- N-channel request/response calculator: next generation of the 4-port calc block, parametrised in channel count and data width.
- Each channel issues a two-beat request (command + operand 1, then operand 2).
- An add/sub unit and a shift unit are shared across channels under round-robin arbitration.
- Adds explicit overflow/underflow detection and invalid-command responses.

Parameters:
- NCH, 4, number of request channels (1..16).
- DW, 32, operand/result width in bits (power of two, >= 8).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state.
- req_cmd_in  input  NCH*4  per-channel command, channel c at bits [4c+3:4c].
- req_data_in  input  NCH*DW  per-channel operand, channel c at [DW*c+DW-1:DW*c].
- out_resp  output  NCH*2  per-channel response code, channel c at [2c+1:2c].
- out_data  output  NCH*DW  per-channel result.

Behaviour:
- Reset: synchronous, active-high. On the reset edge:
  - out_resp = 0 and out_data = 0 for all channels.
  - All channel FSMs go to IDLE.
  - Both arbiter pointers = 0.
  - Pending work is discarded, even mid-operation.
- Commands:
  - 0 = NOP.
  - 1 = ADD.
  - 2 = SUB.
  - 5 = SHL (logical).
  - 6 = SHR (logical).
  - Any other nonzero value is invalid.
- Responses:
  - 0 = none.
  - 1 = success.
  - 2 = invalid command or overflow/underflow.
  - 3 = reserved, never driven.
- Per-channel FSM:
  - IDLE: nonzero cmd sampled at edge k -> capture cmd and op1 -> OP2.
  - OP2: capture req_data_in as op2 at edge k+1 -> WAIT. req_cmd_in is ignored.
  - WAIT: raise a request to the unit matching the cmd. On grant, register result and resp -> RESP. An invalid cmd needs no unit and is granted immediately. req_cmd_in is ignored.
  - RESP: out_resp/out_data hold the result for exactly one cycle.
    - A nonzero cmd sampled in this cycle is accepted (back-to-back) -> OP2.
    - Otherwise -> IDLE.
  - When a channel is not in RESP, its out_resp = 0 and out_data = 0.
- Latency: response is visible in cycle k+3 at minimum (cmd at edge k, op2 at k+1, grant and register at k+2). Each cycle of arbitration loss adds 1.
- Arithmetic:
  - ADD: result = op1+op2. On carry out of DW bits -> resp 2, data 0.
  - SUB: result = op1-op2. If op2 > op1 -> resp 2, data 0.
  - SHL/SHR: op1 shifted by op2[$clog2(DW)-1:0]; upper op2 bits ignored; always resp 1.
  - Invalid cmd: resp 2, data 0.
- Arbitration:
  - Each unit grants at most one channel per cycle.
  - The two units operate concurrently and independently.
  - Round-robin search starts at that unit's pointer and wraps NCH-1 -> 0.
  - After a grant to channel g, that unit's pointer = (g+1) mod NCH. The pointer is unchanged when there is no grant.
  - A waiting channel is served within NCH cycles; no starvation.
- Simultaneous events: reset has priority over any request or grant in the same cycle.

Test Plan:
- Basic ADD: reset, then ch0 cmd=1 data=0x00000001 at cycle 0, data=0x00000002 at cycle 1 -> ch0 resp=1, data=0x00000003 in cycle 3 only; cycle 4 resp=0.
- Overflow/underflow:
  - ch2 ADD 0xFFFFFFFF+0x00000001 -> resp=2, data=0.
  - ch2 SUB 5-7 -> resp=2, data=0.
  - SUB 7-5 -> resp=1, data=2.
- Concurrent units and invalid cmd, all issued at cycle 0:
  - ch0 ADD 3+4 -> resp 1, data 7 in cycle 3.
  - ch1 SHL 0x1 by 33 -> resp 1, data 0x2 in cycle 3.
  - ch3 cmd=3 -> resp 2, data 0 in cycle 3.
- Round-robin:
  - After reset, ch1 ADD alone; add pointer becomes 2.
  - Then ch0 and ch3 issue ADD in the same cycle t -> ch3 responds at t+3, ch0 at t+4.
  - All 4 channels ADD at once after reset -> responses in cycles 3, 4, 5, 6 for ch0..ch3.
- Back-to-back: ch0 issues a new ADD cmd during its RESP cycle 3 with op2 at cycle 4 -> second response in cycle 6; the cmd asserted in cycle 1 (OP2) is ignored.
- Reset mid-operation: ch0 cmd at cycle 0, reset asserted in cycle 2 -> no response ever appears; all outputs 0 from cycle 3.
